// File: rtl/lcrc_pkg.sv
// ---------------------------------------------------------------------------
// lcrc_pkg : shared constants, FSM state type and byte bit-reversal helper
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package lcrc_pkg;

    localparam logic [31:0] LCRC_POLY = 32'h04C11DB7;
    localparam logic [31:0] LCRC_INIT = 32'h0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_t;

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lcrc_byte_engine.sv
// ---------------------------------------------------------------------------
// lcrc_byte_engine : byte-serial CRC-32 register, one byte per step
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lcrc_byte_engine
    import lcrc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        step,
    input  logic [7:0]  din,
    output logic [31:0] crc_stepped
);

    logic [31:0] r_crc;
    logic [31:0] w_crc;
    logic [7:0]  w_din_rev;

    // Bit-reversed byte shifted MSB-first through the polynomial.
    always_comb begin
        w_din_rev = rev8(din);
        w_crc     = r_crc;
        for (int i = 7; i >= 0; i--) begin
            if (w_crc[31] ^ w_din_rev[i]) begin
                w_crc = {w_crc[30:0], 1'b0} ^ LCRC_POLY;
            end else begin
                w_crc = {w_crc[30:0], 1'b0};
            end
        end
    end

    assign crc_stepped = w_crc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_crc <= LCRC_INIT;
        end else if (clear) begin
            r_crc <= LCRC_INIT;
        end else if (step) begin
            r_crc <= w_crc;
        end
    end

endmodule

`default_nettype wire

// File: rtl/lcrc_tx_sched.sv
// ---------------------------------------------------------------------------
// lcrc_tx_sched : replay/new-TLP arbiter sharing one byte-serial LCRC engine
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lcrc_tx_sched
    import lcrc_pkg::*;
#(
    parameter int PACKET_SIZE      = 128,
    parameter int MAX_REPLAY_BURST = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      new_valid,
    input  logic [PACKET_SIZE-1:0]    new_data,
    output logic                      new_ready,
    input  logic                      rpl_valid,
    input  logic [PACKET_SIZE-1:0]    rpl_data,
    output logic                      rpl_ready,
    output logic                      out_valid,
    output logic [PACKET_SIZE+31:0]   out_data,
    input  logic                      out_ready,
    output logic                      out_src,
    output logic                      busy
);

    localparam int NBYTES  = PACKET_SIZE / 8;
    localparam int CNT_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int BURST_W = $clog2(MAX_REPLAY_BURST + 1);
    localparam logic [BURST_W-1:0] C_BURST_MAX = BURST_W'(MAX_REPLAY_BURST);
    localparam logic [CNT_W-1:0]   C_LAST_BYTE = CNT_W'(NBYTES - 1);

    state_t                  r_state;
    logic [PACKET_SIZE-1:0]  r_pkt;
    logic                    r_src;
    logic [CNT_W-1:0]        r_byte_cnt;
    logic [BURST_W-1:0]      r_burst_cnt;

    logic                    w_rpl_wins;
    logic                    w_grant;
    logic [7:0]              w_byte;
    logic [31:0]             w_crc;
    logic [31:0]             w_lcrc;

    // Replay wins unless it has used up its burst while new traffic waits.
    assign w_rpl_wins = rpl_valid && !(new_valid && (r_burst_cnt == C_BURST_MAX));
    assign rpl_ready  = !reset && (r_state == IDLE) && w_rpl_wins;
    assign new_ready  = !reset && (r_state == IDLE) && new_valid && !w_rpl_wins;
    assign w_grant    = rpl_ready || new_ready;

    always_comb begin
        w_byte = r_pkt[(PACKET_SIZE - 1) - 8 * int'(r_byte_cnt) -: 8];
    end

    lcrc_byte_engine u_engine (
        .clk         (clk),
        .reset       (reset),
        .clear       (w_grant),
        .step        (r_state == CALC),
        .din         (w_byte),
        .crc_stepped (w_crc)
    );

    for (genvar k = 0; k < 4; k++) begin : g_lcrc_rev
        assign w_lcrc[8*k +: 8] = rev8(w_crc[8*k +: 8]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_pkt       <= '0;
            r_src       <= 1'b0;
            r_byte_cnt  <= '0;
            r_burst_cnt <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_src     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (rpl_ready) begin
                        r_pkt      <= rpl_data;
                        r_src      <= 1'b1;
                        r_byte_cnt <= '0;
                        r_state    <= CALC;
                        busy       <= 1'b1;
                        if (!new_valid) begin
                            r_burst_cnt <= '0;
                        end else if (r_burst_cnt != C_BURST_MAX) begin
                            r_burst_cnt <= r_burst_cnt + 1'b1;
                        end
                    end else if (new_ready) begin
                        r_pkt       <= new_data;
                        r_src       <= 1'b0;
                        r_byte_cnt  <= '0;
                        r_burst_cnt <= '0;
                        r_state     <= CALC;
                        busy        <= 1'b1;
                    end
                end
                CALC: begin
                    r_byte_cnt <= r_byte_cnt + 1'b1;
                    // Last byte: the engine's stepped value is the final CRC.
                    if (r_byte_cnt == C_LAST_BYTE) begin
                        r_state   <= HOLD;
                        out_valid <= 1'b1;
                        out_data  <= {r_pkt, w_lcrc};
                        out_src   <= r_src;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= IDLE;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lcrc_tx_sched.sv
// ---------------------------------------------------------------------------
// tb_lcrc_tx_sched : directed self-checking bench for lcrc_tx_sched
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_lcrc_tx_sched;

    localparam int PS = 128;
    localparam logic [31:0] POLY = 32'h04C11DB7;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            new_valid = 1'b0;
    logic [PS-1:0]   new_data = '0;
    logic            new_ready;
    logic            rpl_valid = 1'b0;
    logic [PS-1:0]   rpl_data = '0;
    logic            rpl_ready;
    logic            out_valid;
    logic [PS+31:0]  out_data;
    logic            out_ready = 1'b0;
    logic            out_src;
    logic            busy;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    lcrc_tx_sched #(.PACKET_SIZE(PS), .MAX_REPLAY_BURST(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .new_valid (new_valid),
        .new_data  (new_data),
        .new_ready (new_ready),
        .rpl_valid (rpl_valid),
        .rpl_data  (rpl_data),
        .rpl_ready (rpl_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .out_src   (out_src),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bit-serial reference: each byte high-to-low, its bits LSB first.
    function automatic logic [31:0] ref_lcrc(input logic [PS-1:0] p);
        logic [31:0] c = 32'h0;
        logic [31:0] r;
        for (int b = PS/8 - 1; b >= 0; b--) begin
            for (int i = 0; i < 8; i++) begin
                if (c[31] ^ p[8*b + i]) c = {c[30:0], 1'b0} ^ POLY;
                else                    c = {c[30:0], 1'b0};
            end
        end
        for (int k = 0; k < 32; k++) r[8*(k/8) + (k%8)] = c[8*(k/8) + 7 - (k%8)];
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic src, input logic [PS-1:0] d, input string tag);
        int n = 0;
        if (src) begin rpl_valid = 1'b1; rpl_data = d; end
        else     begin new_valid = 1'b1; new_data = d; end
        #1;
        while (!(src ? rpl_ready : new_ready) && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_grant"}, src ? rpl_ready : new_ready, 1'b1);
        check({tag, "_excl"}, rpl_ready & new_ready, 1'b0);
        tick();
        if (src) rpl_valid = 1'b0;
        else     new_valid = 1'b0;
    endtask

    task automatic wait_out(input logic src, input logic [PS-1:0] d, input logic [31:0] lcrc,
                            input string tag);
        int n = 1;
        while (!out_valid && n < 60) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, n, 17);
        check({tag, "_data"}, out_data, {d, lcrc});
        check({tag, "_src"}, out_src, src);
        check({tag, "_nogrant"}, {new_ready, rpl_ready}, 2'b00);
    endtask

    task automatic finish_out(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_drop"}, out_valid, 1'b0);
    endtask

    initial begin
        logic [PS-1:0]  d;
        logic [PS-1:0]  dr;
        logic [PS-1:0]  dn;
        logic [PS+31:0] held;
        logic           exp_r;

        // Reset state, readies forced low even with requests present
        new_valid = 1'b1;
        rpl_valid = 1'b1;
        #2;
        check("rst_ready", {new_ready, rpl_ready}, 2'b00);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, '0);
        check("rst_out_src", out_src, 1'b0);
        check("rst_busy", busy, 1'b0);
        new_valid = 1'b0;
        rpl_valid = 1'b0;
        tick();
        reset = 1'b0;

        // out_ready with nothing pending is ignored
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        check("idle_oready_valid", out_valid, 1'b0);
        check("idle_oready_busy", busy, 1'b0);

        // All-zero packet
        send(1'b0, '0, "zero");
        check("zero_busy", busy, 1'b1);
        wait_out(1'b0, '0, 32'h00000000, "zero");
        finish_out("zero");

        // Single low byte values, hand-derived
        d = 128'h80;
        send(1'b0, d, "b80");
        wait_out(1'b0, d, 32'h2083B8ED, "b80");
        finish_out("b80");
        d = 128'h40;
        send(1'b0, d, "b40");
        wait_out(1'b0, d, 32'h9041DC76, "b40");
        finish_out("b40");
        d = 128'h20;
        send(1'b1, d, "b20");
        wait_out(1'b1, d, 32'hC8206E3B, "b20");
        finish_out("b20");

        // Backpressure in HOLD with a replay pending
        d = 128'h0123456789ABCDEF_FEDCBA9876543210;
        send(1'b1, d, "bp");
        wait_out(1'b1, d, ref_lcrc(d), "bp");
        held = out_data;
        rpl_valid = 1'b1;
        rpl_data = 128'hA5;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid", out_valid, 1'b1);
            check("bp_stable", out_data, held);
            check("bp_nogrant", rpl_ready, 1'b0);
        end
        finish_out("bp");
        check("bp_next_grant", rpl_ready, 1'b1);
        send(1'b1, 128'hA5, "bp2");
        wait_out(1'b1, 128'hA5, ref_lcrc(128'hA5), "bp2");
        finish_out("bp2");

        // Reset during CALC byte 5, then the same request completes
        d = 128'hDEADBEEF_00112233_44556677_8899AABB;
        send(1'b0, d, "rst");
        repeat (5) tick();
        new_valid = 1'b1;
        reset = 1'b1;
        #1;
        check("rst_mid_valid", out_valid, 1'b0);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_ready", new_ready, 1'b0);
        tick();
        reset = 1'b0;
        send(1'b0, d, "rst2");
        wait_out(1'b0, d, ref_lcrc(d), "rst2");
        finish_out("rst2");

        // Both sources held: R,R,R,R,N,R,R,R,R,N
        dr = 128'h11112222_33334444_55556666_77778888;
        dn = 128'h9999AAAA_BBBBCCCC_DDDDEEEE_FFFF0000;
        rpl_data = dr;
        new_data = dn;
        rpl_valid = 1'b1;
        new_valid = 1'b1;
        #1;
        for (int i = 0; i < 10; i++) begin
            exp_r = (i % 5) != 4;
            check("burst_rpl", rpl_ready, exp_r);
            check("burst_new", new_ready, !exp_r);
            tick();
            wait_out(exp_r, exp_r ? dr : dn, ref_lcrc(exp_r ? dr : dn), "burst");
            finish_out("burst");
        end
        rpl_valid = 1'b0;
        new_valid = 1'b0;

        // Pseudo-random packets, alternating sources
        for (int i = 0; i < 4; i++) begin
            d = {$urandom(), $urandom(), $urandom(), $urandom()};
            send(i[0], d, "rand");
            wait_out(i[0], d, ref_lcrc(d), "rand");
            finish_out("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

`default_nettype wire
